mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of cycles between request capture and access (legal range 0-15).
REQ-002 The block SHALL have parameter MEM_BYTES, default 512, meaning the byte capacity of the storage array.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Clr, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have port MFA, input, 1, the memory-function-active request from the datapath.
REQ-006 The block SHALL have port MOP, input, 6, the SPARC op3 memory opcode.
REQ-007 The block SHALL have port ADDR, input, 9, the byte address.
REQ-008 The block SHALL have port DataIn, input, 32, the store data, right-justified.
REQ-009 The block SHALL have port DataOut, output, 32, the load data, right-justified and extended.
REQ-010 The block SHALL have port MFC, output, 1, the memory-function-complete acknowledge.
REQ-011 The block SHALL have port ERR, output, 1, a flag for an illegal opcode or misaligned access, valid while MFC=1.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, ACCESS, DONE; the reset state is IDLE.
REQ-013 In IDLE with MFA=1, the block SHALL capture MOP, ADDR and DataIn into internal registers and go to WAIT. When WAIT_CYCLES=0, it goes directly to ACCESS.
REQ-014 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit counter, then go to ACCESS.
REQ-015 If MFA=0 in WAIT, the block SHALL abort: return to IDLE with no write and no MFC pulse.
REQ-016 ACCESS SHALL take one cycle to perform the read or write on the captured values, then go to DONE.
REQ-017 In DONE, MFC SHALL be 1, and DataOut and ERR SHALL be held stable until MFA is sampled 0.
REQ-018 When MFA is sampled 0 in DONE, the block SHALL set MFC to 0 the next cycle and return to IDLE.
REQ-019 A new request SHALL be accepted only from IDLE. MFA held high after DONE→IDLE is treated as a new request.
REQ-020 Minimum latency from MFA rise to MFC rise SHALL be WAIT_CYCLES+2 cycles.
REQ-021 The block SHALL support exactly these opcodes:
 - 000000 LD: word load
 - 000001 LDUB: unsigned byte load
 - 000010 LDUH: unsigned halfword load
 - 001001 LDSB: signed byte load
 - 001010 LDSH: signed halfword load
 - 000100 ST: word store
 - 000101 STB: byte store
 - 000110 STH: halfword store
REQ-022 Storage SHALL be big-endian: the byte at ADDR is the most significant byte of the halfword or word.
REQ-023 Stores SHALL write only the addressed bytes, taking the low 8/16/32 bits of DataIn.
REQ-024 Byte and halfword loads SHALL zero-extend (LDUB, LDUH) or sign-extend (LDSB, LDSH) to 32 bits.
REQ-025 Alignment SHALL be enforced as follows:
 - A halfword access with ADDR[0]=1 is misaligned.
 - A word access with ADDR[1:0]≠00 is misaligned.
 - A misaligned access or any unlisted opcode results in ERR=1, no write, DataOut=0, and normal handshake completion.
REQ-026 For a store, DataOut SHALL be 0 in DONE.
REQ-027 Addresses SHALL NOT wrap. Accessed bytes always lie in ADDR..ADDR+3 and never exceed 511 when aligned.
REQ-028 Changes on MOP, ADDR or DataIn after capture SHALL have no effect on the current transaction.

Reset
REQ-029 With Clr=0 at a rising Clk edge, the block SHALL go to IDLE, set MFC=0, ERR=0, DataOut=0, and clear the wait counter and captured registers.
REQ-030 Reset mid-transaction SHALL abort it: a store not yet in ACCESS is not written, and no MFC follows.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 While Clr=0, MFA SHALL be ignored.

Verification
REQ-033 Word round trip: ST 0xDEADBEEF @0x010, then LD @0x010 → DataOut=0xDEADBEEF, ERR=0, MFC rises 4 cycles after MFA (WAIT_CYCLES=2).
REQ-034 Byte/halfword endianness and extension: after ST 0x80FF7F01 @0x020, check the following loads:
 - LDUB @0x020 → 0x00000080
 - LDSB @0x020 → 0xFFFFFF80
 - LDSH @0x022 → 0x00007F01
 - LDUH @0x020 → 0x000080FF
REQ-035 Partial store: STB 0x12 @0x021 over word 0x80FF7F01, then LD @0x020 → 0x80127F01.
REQ-036 Errors: LD @0x013 → MFC=1, ERR=1, DataOut=0, and memory unchanged; opcode 111111 @0x000 → ERR=1.
REQ-037 Abort cases, each followed by LD @0x030 returning the old value:
 - MFA dropped in WAIT during ST @0x030 → no MFC.
 - Clr=0 asserted in WAIT → MFC=0.
REQ-038 Handshake hold: MFA held 10 cycles after MFC rises → MFC and DataOut stable throughout; MFC falls one cycle after MFA falls.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-addressed big-endian memory slave with MFA/MFC handshake.
// SPARC op3 load/store decode, programmable wait states, error flag.
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_BYTES   = 512
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MFA,
    input  logic [5:0]  MOP,
    input  logic [8:0]  ADDR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        ERR
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] dout_q, dout_d;
    logic        mfc_q, mfc_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [MEM_BYTES];

    logic        legal, is_st, sgn, misal, acc_err;
    logic [1:0]  sz;
    logic [8:0]  a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] rdata;

    always_comb begin
        legal = 1'b1;
        is_st = 1'b0;
        sgn   = 1'b0;
        sz    = 2'd2;
        case (op_q)
            6'b000000: sz = 2'd2;
            6'b000001: sz = 2'd0;
            6'b000010: sz = 2'd1;
            6'b001001: begin sz = 2'd0; sgn = 1'b1; end
            6'b001010: begin sz = 2'd1; sgn = 1'b1; end
            6'b000100: begin sz = 2'd2; is_st = 1'b1; end
            6'b000101: begin sz = 2'd0; is_st = 1'b1; end
            6'b000110: begin sz = 2'd1; is_st = 1'b1; end
            default:   legal = 1'b0;
        endcase
        misal = ((sz == 2'd1) && addr_q[0]) ||
                ((sz == 2'd2) && (addr_q[1:0] != 2'b00));
        acc_err = !legal || misal;

        a1 = addr_q + 9'd1;
        a2 = addr_q + 9'd2;
        a3 = addr_q + 9'd3;
        b0 = mem_q[addr_q];
        b1 = mem_q[a1];
        b2 = mem_q[a2];
        b3 = mem_q[a3];

        case (sz)
            2'd0:    rdata = {{24{sgn & b0[7]}}, b0};
            2'd1:    rdata = {{16{sgn & b0[7]}}, b0, b1};
            default: rdata = {b0, b1, b2, b3};
        endcase
        if (acc_err || is_st) rdata = 32'd0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (MFA) begin
                    op_d    = MOP;
                    addr_d  = ADDR;
                    din_d   = DataIn;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (!MFA) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACCESS: begin
                dout_d  = rdata;
                err_d   = acc_err;
                mfc_d   = 1'b1;
                state_d = DONE;
            end
            default: begin
                if (!MFA) begin
                    mfc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= 9'd0;
            din_q   <= 32'd0;
            dout_q  <= 32'd0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset; contents survive Clr.
    always_ff @(posedge Clk) begin
        if (Clr && state_q == ACCESS && is_st && !acc_err) begin
            case (sz)
                2'd0: mem_q[addr_q] <= din_q[7:0];
                2'd1: begin
                    mem_q[addr_q] <= din_q[15:8];
                    mem_q[a1]     <= din_q[7:0];
                end
                default: begin
                    mem_q[addr_q] <= din_q[31:24];
                    mem_q[a1]     <= din_q[23:16];
                    mem_q[a2]     <= din_q[15:8];
                    mem_q[a3]     <= din_q[7:0];
                end
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MFC     = mfc_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed load/store vectors,
// error, abort, reset and handshake-hold cases.
module tb_mem_responder;

    localparam int WC = 2;

    localparam logic [5:0] LD   = 6'b000000;
    localparam logic [5:0] LDUB = 6'b000001;
    localparam logic [5:0] LDUH = 6'b000010;
    localparam logic [5:0] LDSB = 6'b001001;
    localparam logic [5:0] LDSH = 6'b001010;
    localparam logic [5:0] ST   = 6'b000100;
    localparam logic [5:0] STB  = 6'b000101;
    localparam logic [5:0] STH  = 6'b000110;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        MFA = 1'b0;
    logic [5:0]  MOP = 6'd0;
    logic [8:0]  ADDR = 9'd0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] DataOut;
    logic        MFC;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        string       name;
    } exp_t;

    exp_t sb[$];

    mem_responder #(.WAIT_CYCLES(WC), .MEM_BYTES(512)) dut (
        .Clk(Clk),
        .Clr(Clr),
        .MFA(MFA),
        .MOP(MOP),
        .ADDR(ADDR),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .MFC(MFC),
        .ERR(ERR)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation on every MFC rising edge.
    initial begin
        logic prev;
        exp_t x;
        prev = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (MFC === 1'b1 && prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mfc: got MFC=1 expected none");
                end else begin
                    x = sb.pop_front();
                    chk({x.name, "_data"}, DataOut, x.d);
                    chk({x.name, "_err"}, {31'd0, ERR}, {31'd0, x.e});
                end
            end
            prev = MFC;
        end
    end

    task automatic req(input string name, input logic [5:0] op,
                       input logic [8:0] a, input logic [31:0] din,
                       input logic [31:0] ed, input logic ee,
                       input int hold);
        int n;
        logic [31:0] held;
        exp_t x;
        x.d = ed;
        x.e = ee;
        x.name = name;
        sb.push_back(x);
        MOP = op;
        ADDR = a;
        DataIn = din;
        MFA = 1'b1;
        n = 0;
        while (1) begin
            @(posedge Clk);
            #1;
            n++;
            if (n == 1) begin
                MOP = ~op;
                ADDR = ~a;
                DataIn = ~din;
            end
            if (MFC === 1'b1 || n > 40) break;
        end
        if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no MFC expected MFC", name);
        end else begin
            chk({name, "_lat"}, n, WC + 2);
            held = DataOut;
            for (int i = 0; i < hold; i++) begin
                @(posedge Clk);
                #1;
                chk({name, "_hold_mfc"}, {31'd0, MFC}, 32'd1);
                chk({name, "_hold_data"}, DataOut, held);
            end
        end
        MFA = 1'b0;
        @(posedge Clk);
        #1;
        chk({name, "_mfc_fall"}, {31'd0, MFC}, 32'd0);
        @(posedge Clk);
        #1;
    endtask

    task automatic abort_mfa(input logic [8:0] a, input logic [31:0] din);
        MOP = ST;
        ADDR = a;
        DataIn = din;
        MFA = 1'b1;
        @(posedge Clk);
        #1;
        MFA = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            chk("abort_mfa_nomfc", {31'd0, MFC}, 32'd0);
        end
    endtask

    task automatic abort_clr(input logic [8:0] a, input logic [31:0] din);
        MOP = ST;
        ADDR = a;
        DataIn = din;
        MFA = 1'b1;
        @(posedge Clk);
        #1;
        Clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            chk("abort_clr_mfc", {31'd0, MFC}, 32'd0);
        end
        MFA = 1'b0;
        Clr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            chk("abort_clr_nomfc", {31'd0, MFC}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_mfc", {31'd0, MFC}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_data", DataOut, 32'd0);
        Clr = 1'b1;
        @(posedge Clk);
        #1;

        req("st_word", ST, 9'h010, 32'hDEADBEEF, 32'd0, 1'b0, 0);
        req("ld_word", LD, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        req("st_pat", ST, 9'h020, 32'h80FF7F01, 32'd0, 1'b0, 0);
        req("ldub", LDUB, 9'h020, 32'h0, 32'h00000080, 1'b0, 0);
        req("ldsb", LDSB, 9'h020, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        req("ldsh22", LDSH, 9'h022, 32'h0, 32'h00007F01, 1'b0, 0);
        req("lduh", LDUH, 9'h020, 32'h0, 32'h000080FF, 1'b0, 0);
        req("ldsh20", LDSH, 9'h020, 32'h0, 32'hFFFF80FF, 1'b0, 0);
        req("ldub23", LDUB, 9'h023, 32'h0, 32'h00000001, 1'b0, 0);

        req("stb", STB, 9'h021, 32'hCAFE0012, 32'd0, 1'b0, 0);
        req("ld_stb", LD, 9'h020, 32'h0, 32'h80127F01, 1'b0, 0);
        req("sth", STH, 9'h022, 32'h1234BEEF, 32'd0, 1'b0, 0);
        req("ld_sth", LD, 9'h020, 32'h0, 32'h8012BEEF, 1'b0, 0);

        req("ld_mis", LD, 9'h013, 32'h0, 32'd0, 1'b1, 0);
        req("st_mis", ST, 9'h011, 32'h0, 32'd0, 1'b1, 0);
        req("sth_mis", STH, 9'h011, 32'h5555, 32'd0, 1'b1, 0);
        req("ld_intact", LD, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        req("lduh_mis", LDUH, 9'h021, 32'h0, 32'd0, 1'b1, 0);
        req("bad_op", 6'b111111, 9'h000, 32'h0, 32'd0, 1'b1, 0);

        req("st_top", ST, 9'h1FC, 32'h01020304, 32'd0, 1'b0, 0);
        req("ldub_top", LDUB, 9'h1FF, 32'h0, 32'h00000004, 1'b0, 0);

        req("st30", ST, 9'h030, 32'h11223344, 32'd0, 1'b0, 0);
        abort_mfa(9'h030, 32'hAAAAAAAA);
        req("ld30_a", LD, 9'h030, 32'h0, 32'h11223344, 1'b0, 0);
        abort_clr(9'h030, 32'hBBBBBBBB);
        req("ld30_b", LD, 9'h030, 32'h0, 32'h11223344, 1'b0, 0);

        req("hold", LD, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 10);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
